// File: rtl/axis_seq_source.sv
// AXI4-Stream master emitting fixed-length packets of sequence-numbered beats,
// with a programmable inter-packet gap and accepted beat/packet counters.
module axis_seq_source #(
    parameter int unsigned            TDATA_BITS = 32,
    parameter int unsigned            PKT_LEN    = 16,
    parameter int unsigned            GAP_CYCLES = 4,
    parameter logic [TDATA_BITS-1:0]  SEQ_INIT   = '0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    output logic [TDATA_BITS-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           beat_count,
    output logic [31:0]           pkt_count
);

    localparam int unsigned CNT_BITS = 16;
    localparam int unsigned CTR_BITS = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(PKT_LEN - 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST = CNT_BITS'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic                FIRST_IS_LAST = (PKT_LEN == 1);
    localparam logic                HAS_GAP       = (GAP_CYCLES > 0);

    logic [1:0]            state_q,      state_d;
    logic                  tvalid_q,     tvalid_d;
    logic                  tlast_q,      tlast_d;
    logic [TDATA_BITS-1:0] tdata_q,      tdata_d;
    logic                  busy_q,       busy_d;
    logic [TDATA_BITS-1:0] seq_q,        seq_d;
    logic [CNT_BITS-1:0]   beat_idx_q,   beat_idx_d;
    logic [CNT_BITS-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [CTR_BITS-1:0]   beat_count_q, beat_count_d;
    logic [CTR_BITS-1:0]   pkt_count_q,  pkt_count_d;

    logic                  hs_c;
    logic [TDATA_BITS-1:0] next_seq_c;
    logic [CNT_BITS-1:0]   next_idx_c;

    assign hs_c       = tvalid_q & m_axis_tready;
    assign next_seq_c = seq_q + TDATA_BITS'(1);
    assign next_idx_c = beat_idx_q + CNT_BITS'(1);

    // State register; reset aborts any packet in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= SEQ_INIT;
            busy_q       <= 1'b0;
            seq_q        <= SEQ_INIT;
            beat_idx_q   <= '0;
            gap_cnt_q    <= '0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tdata_q      <= tdata_d;
            busy_q       <= busy_d;
            seq_q        <= seq_d;
            beat_idx_q   <= beat_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tdata_d      = tdata_q;
        seq_d        = seq_q;
        beat_idx_d   = beat_idx_q;
        gap_cnt_d    = gap_cnt_q;
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SEND;
                    tvalid_d   = 1'b1;
                    tdata_d    = seq_q;
                    beat_idx_d = '0;
                    tlast_d    = FIRST_IS_LAST;
                end
            end

            ST_SEND: begin
                // tdata/tlast only move on a handshake, so stalls hold them stable.
                if (hs_c) begin
                    seq_d        = next_seq_c;
                    beat_count_d = beat_count_q + CTR_BITS'(1);
                    if (!tlast_q) begin
                        beat_idx_d = next_idx_c;
                        tlast_d    = (next_idx_c == LAST_IDX);
                        tdata_d    = next_seq_c;
                    end else begin
                        pkt_count_d = pkt_count_q + CTR_BITS'(1);
                        if (HAS_GAP) begin
                            state_d   = ST_GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = '0;
                        end else if (enable) begin
                            beat_idx_d = '0;
                            tlast_d    = FIRST_IS_LAST;
                            tdata_d    = next_seq_c;
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end
                end
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + CNT_BITS'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    if (enable) begin
                        state_d    = ST_SEND;
                        tvalid_d   = 1'b1;
                        tdata_d    = seq_q;
                        beat_idx_d = '0;
                        tlast_d    = FIRST_IS_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign beat_count    = beat_count_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_seq_source.sv
// Bench for axis_seq_source: two configurations driven together, each tracked
// by a beat-level reference model of sequence, framing, gap and counters.
module tb_axis_seq_source;

    localparam int unsigned A_BITS = 32;
    localparam int unsigned A_LEN  = 4;
    localparam int unsigned A_GAP  = 2;
    localparam int unsigned A_SEQ  = 0;
    localparam int unsigned B_BITS = 8;
    localparam int unsigned B_LEN  = 1;
    localparam int unsigned B_GAP  = 0;
    localparam int unsigned B_SEQ  = 254;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic en_a = 1'b0, rdy_a = 1'b0, en_b = 1'b0, rdy_b = 1'b0;

    logic [A_BITS-1:0] tdata_a;
    logic              tvalid_a, tlast_a, busy_a;
    logic [31:0]       beat_count_a, pkt_count_a;
    logic [B_BITS-1:0] tdata_b;
    logic              tvalid_b, tlast_b, busy_b;
    logic [31:0]       beat_count_b, pkt_count_b;

    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        int unsigned n;      // beats accepted since reset
        logic        pv;     // tvalid seen last cycle
        logic        pl;     // tlast seen last cycle
        logic [63:0] pd;     // tdata seen last cycle
        int unsigned run;    // idle cycles since last tlast handshake
        logic        armed;  // a tlast handshake awaits the next first beat
        logic        gap_ok; // enable held high since that handshake
    } mon_t;

    mon_t ma, mb;

    axis_seq_source #(
        .TDATA_BITS(A_BITS), .PKT_LEN(A_LEN), .GAP_CYCLES(A_GAP), .SEQ_INIT(A_BITS'(A_SEQ))
    ) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .enable(en_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(rdy_a),
        .m_axis_tlast(tlast_a), .busy(busy_a),
        .beat_count(beat_count_a), .pkt_count(pkt_count_a)
    );

    axis_seq_source #(
        .TDATA_BITS(B_BITS), .PKT_LEN(B_LEN), .GAP_CYCLES(B_GAP), .SEQ_INIT(B_BITS'(B_SEQ))
    ) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .enable(en_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(rdy_b),
        .m_axis_tlast(tlast_b), .busy(busy_b),
        .beat_count(beat_count_b), .pkt_count(pkt_count_b)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic mon_t mon_clear();
        mon_t m;
        m.n = 0; m.pv = 1'b0; m.pl = 1'b0; m.pd = '0;
        m.run = 0; m.armed = 1'b0; m.gap_ok = 1'b0;
        return m;
    endfunction

    // Reference: accepted beat k carries SEQ_INIT+k and is last when k%LEN==LEN-1.
    task automatic monitor(input string tag, input int unsigned seq_init, input int unsigned len,
                           input int unsigned gap, input int unsigned bits,
                           input logic vld, input logic lst, input logic bsy,
                           input logic [63:0] dat, input logic [31:0] bc, input logic [31:0] pc,
                           input logic rdy, input logic en, inout mon_t m);
        logic [63:0] mask;
        logic [63:0] exp_dat;
        mask = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
        if (!aresetn) begin
            check({tag, "_rst_valid"}, 64'(vld), 64'd0);
            check({tag, "_rst_last"}, 64'(lst), 64'd0);
            check({tag, "_rst_data"}, dat, 64'(seq_init) & mask);
            check({tag, "_rst_busy"}, 64'(bsy), 64'd0);
            check({tag, "_rst_beats"}, 64'(bc), 64'd0);
            check({tag, "_rst_pkts"}, 64'(pc), 64'd0);
            m = mon_clear();
            return;
        end
        if (m.pv && rdy) begin
            m.n++;
            if (m.pl) begin
                m.armed = 1'b1; m.run = 0; m.gap_ok = 1'b1;
            end
        end
        if (m.armed) m.gap_ok = m.gap_ok & en;
        if (m.pv && !(rdy && m.pl)) check({tag, "_no_drop"}, 64'(vld), 64'd1);
        if (m.pv && !rdy) begin
            check({tag, "_stall_data"}, dat, m.pd);
            check({tag, "_stall_last"}, 64'(lst), 64'(m.pl));
        end
        check({tag, "_beat_count"}, 64'(bc), 64'(m.n));
        check({tag, "_pkt_count"}, 64'(pc), 64'(m.n / len));
        if (vld) begin
            exp_dat = (64'(seq_init) + 64'(m.n)) & mask;
            check({tag, "_data"}, dat, exp_dat);
            check({tag, "_last"}, 64'(lst), 64'((m.n % len) == (len - 1)));
            check({tag, "_busy"}, 64'(bsy), 64'd1);
            if (m.armed) begin
                if (m.gap_ok) check({tag, "_gap_len"}, 64'(m.run), 64'(gap));
                m.armed = 1'b0;
            end
        end else begin
            exp_dat = (m.n == 0) ? (64'(seq_init) & mask)
                                 : ((64'(seq_init) + 64'(m.n) - 64'd1) & mask);
            check({tag, "_idle_hold"}, dat, exp_dat);
            if (m.armed) m.run++;
        end
        m.pv = vld; m.pl = lst; m.pd = dat;
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
        monitor("a", A_SEQ, A_LEN, A_GAP, A_BITS, tvalid_a, tlast_a, busy_a, 64'(tdata_a),
                beat_count_a, pkt_count_a, rdy_a, en_a, ma);
        monitor("b", B_SEQ, B_LEN, B_GAP, B_BITS, tvalid_b, tlast_b, busy_b, 64'(tdata_b),
                beat_count_b, pkt_count_b, rdy_b, en_b, mb);
    endtask

    task automatic wait_beats_a(input int unsigned target, input int unsigned budget);
        int unsigned k = 0;
        while (ma.n < target && k < budget) begin
            cycle();
            k++;
        end
        if (ma.n < target) check("a_wait_beats_timeout", 64'(ma.n), 64'(target));
    endtask

    task automatic wait_idle_a(input int unsigned budget);
        int unsigned k = 0;
        while (tvalid_a && k < budget) begin
            cycle();
            k++;
        end
        if (tvalid_a) check("a_wait_idle_timeout", 64'(tvalid_a), 64'd0);
    endtask

    logic [7:0] wrap_exp [4];

    initial begin
        ma = mon_clear();
        mb = mon_clear();
        wrap_exp[0] = 8'd254; wrap_exp[1] = 8'd255; wrap_exp[2] = 8'd0; wrap_exp[3] = 8'd1;

        aresetn = 1'b0;
        repeat (3) cycle();
        aresetn = 1'b1;
        repeat (2) cycle();
        check("a_idle_valid", 64'(tvalid_a), 64'd0);
        check("a_idle_busy", 64'(busy_a), 64'd0);

        // Basic packets, one-cycle enable latency and 8-bit wrap on b.
        en_a = 1'b1; en_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        cycle();
        check("a_latency_valid", 64'(tvalid_a), 64'd1);
        check("a_first_data", 64'(tdata_a), 64'd0);
        check("b_wrap_0", 64'(tdata_b), 64'(wrap_exp[0]));
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("b_wrap", 64'(tdata_b), 64'(wrap_exp[i]));
        end
        wait_beats_a(8, 40);
        check("a_pkts_after_8", 64'(pkt_count_a), 64'd2);
        repeat (12) cycle();
        check("b_continuous_valid", 64'(tvalid_b), 64'd1);
        check("b_pkts_eq_beats", 64'(pkt_count_b), 64'(mb.n));

        // enable dropped mid-packet: packet completes, then idle.
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
        wait_beats_a(2, 20);
        en_a = 1'b0;
        wait_idle_a(20);
        repeat (4) cycle();
        check("a_drop_valid", 64'(tvalid_a), 64'd0);
        check("a_drop_busy", 64'(busy_a), 64'd0);
        check("a_drop_beats", 64'(beat_count_a), 64'd4);
        check("a_drop_pkts", 64'(pkt_count_a), 64'd1);

        // Reset while beat 2 is stalled.
        en_a = 1'b1;
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
        wait_beats_a(2, 20);
        rdy_a = 1'b0;
        repeat (2) cycle();
        check("a_stall_valid", 64'(tvalid_a), 64'd1);
        check("a_stall_beat2", 64'(tdata_a), 64'd2);
        aresetn = 1'b0;
        cycle();
        check("a_abort_valid", 64'(tvalid_a), 64'd0);
        check("a_abort_beats", 64'(beat_count_a), 64'd0);
        aresetn = 1'b1;
        rdy_a = 1'b1;
        cycle();
        check("a_restart_valid", 64'(tvalid_a), 64'd1);
        check("a_restart_data", 64'(tdata_a), 64'(A_SEQ));
        wait_beats_a(4, 20);
        check("a_restart_pkts", 64'(pkt_count_a), 64'd1);

        // Random backpressure with occasional enable drops.
        for (int i = 0; i < 1000; i++) begin
            rdy_a = 1'($urandom % 2);
            rdy_b = 1'($urandom % 2);
            en_a  = (($urandom % 8) != 0);
            en_b  = (($urandom % 8) != 0);
            cycle();
        end
        check("a_random_progress", 64'(ma.n > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_seq_source.md
Name: axis_seq_source

Overview:
- AXI4-Stream master that generates fixed-length packets of sequence-numbered beats.
- Drives the s_axis_* input of the downstream sink in the CDC timing demo. Sits on the aclk side feeding that consumer.
- Provides a checkable, backpressure-compliant traffic source with programmable packet length and inter-packet gap.
- Exports beat and packet counters for ILA/LED observation.

Parameters:
- TDATA_BITS, 32, width of m_axis_tdata and of the sequence counter (8..64).
- PKT_LEN, 16, beats per packet, legal range 1..65535.
- GAP_CYCLES, 4, idle cycles with tvalid low between packets, legal range 0..65535.
- SEQ_INIT, 0, sequence value of the first beat after reset.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- enable  in  1  level; high permits packet generation (sampled at packet boundaries).
- m_axis_tdata  out  TDATA_BITS  current beat sequence number.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the final beat of each packet.
- busy  out  1  high while in the SEND or GAP state.
- beat_count  out  32  accepted beats since reset.
- pkt_count  out  32  accepted packets since reset (counted on a tlast handshake).

Behaviour:
- All outputs are registered. tvalid never depends combinationally on tready.
- Handshake: a beat is accepted on a cycle where tvalid=1 and tready=1.
- Reset (aresetn=0 at a clock edge):
  - state=IDLE.
  - tvalid=0, tlast=0, tdata=SEQ_INIT, busy=0, beat_count=0, pkt_count=0.
  - Internal seq=SEQ_INIT, beat_idx=0, gap_cnt=0.
- Reset mid-packet aborts immediately. The next packet after reset starts at SEQ_INIT with beat_idx=0.
- States:
  - IDLE: tvalid=0. If enable=1, the next cycle is SEND with tvalid=1, tdata=seq, beat_idx=0, tlast=(PKT_LEN==1). Latency from enable to tvalid is 1 cycle.
  - SEND: tvalid=1.
    - While tready=0, tdata and tlast hold stable (AXIS rule).
    - On a handshake: seq<=seq+1 (wraps modulo 2^TDATA_BITS), beat_count<=beat_count+1.
    - On a handshake with tlast=0: beat_idx<=beat_idx+1, and tlast<=(beat_idx+1==PKT_LEN-1).
    - On a handshake with tlast=1: pkt_count<=pkt_count+1, then take the transition below.
  - Transition after a tlast handshake:
    - If GAP_CYCLES>0: go to GAP, tvalid<=0, gap_cnt<=0.
    - Else if enable=1: stay in SEND. The next beat is presented the very next cycle (back-to-back packets), with beat_idx=0 and tlast=(PKT_LEN==1).
    - Else: go to IDLE, tvalid<=0.
  - GAP: tvalid=0. gap_cnt increments each cycle. When gap_cnt==GAP_CYCLES-1:
    - if enable=1, go to SEND (first beat presented next cycle);
    - else go to IDLE.
    - Exactly GAP_CYCLES cycles with tvalid=0 occur between the tlast beat and the next first beat.
- enable deassert:
  - Mid-packet deassert has no effect until the packet completes. A packet is never truncated.
  - Deassert in GAP is honoured at the end of the gap.
- busy=1 in SEND and GAP, 0 in IDLE.
- Counters wrap modulo 2^32 with no saturation.
- Sequence continuity: consecutive accepted beats differ by exactly +1 modulo 2^TDATA_BITS, across packet boundaries.
- tdata is only meaningful while tvalid=1, but it must still hold its last value while tvalid=0.

Test Plan:
- Reset, enable=1, tready=1, PKT_LEN=4, GAP_CYCLES=2 -> tvalid first high 1 cycle after enable; tdata 0,1,2,3 with tlast on 3; 2 cycles of tvalid=0; next beats 4..7; pkt_count=2 after 8 beats.
- Random tready (50%) for 1000 cycles -> tdata/tlast stable whenever tvalid&&!tready; accepted sequence gap-free; beat_count equals handshake count; pkt_count=beat_count/PKT_LEN.
- enable dropped after beat 1 of a PKT_LEN=4 packet -> beats 2,3 still sent, tlast on 3; then IDLE with busy=0 and tvalid=0.
- GAP_CYCLES=0, PKT_LEN=1, tready=1 -> tvalid continuously high; tlast=1 on every beat; pkt_count==beat_count.
- TDATA_BITS=8, SEQ_INIT=254 -> tdata 254,255,0,1 on consecutive accepted beats.
- aresetn pulsed low during beat 2 with tready=0 -> next cycle tvalid=0, counters=0; restart begins at SEQ_INIT with a full PKT_LEN packet.
